// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read handshake between the fetch unit and instruction memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues the read, receives the data
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: accepts the read, returns the data
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding word read, holds the fetched
// instruction until consumed, and absorbs branch redirects at any point.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master imem,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        instruction,
  output logic [6:0]         Opcode,
  output logic [31:0]        pc,
  output logic               instr_valid
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 7;
  localparam logic [XLEN-1:0] ADDR_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            pending_q, pending_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;

  logic [XLEN-1:0] target_aligned;
  logic            ack_discard;

  // Redirect targets are always word aligned
  assign target_aligned = branch_target & ALIGN_MASK;

  // Returned data is stale if a redirect is pending or arrives this cycle
  assign ack_discard = pending_q | branch_taken;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_ack && !ack_discard) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken || !stall) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state so they are registered
  always_comb begin
    imem_req_d    = 1'b0;
    instr_valid_d = 1'b0;
    case (state_d)
      REQ:     imem_req_d    = 1'b1;
      HOLD:    instr_valid_d = 1'b1;
      default: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // Address, redirect and instruction-capture datapath
  always_comb begin
    req_addr_d    = req_addr_q;
    redirect_pc_d = redirect_pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pending_d     = pending_q;
    case (state_q)
      IDLE: begin
        if (branch_taken) begin
          req_addr_d = target_aligned;
        end
      end
      REQ: begin
        if (imem.imem_ack) begin
          if (branch_taken) begin
            req_addr_d = target_aligned;
            pending_d  = 1'b0;
          end else if (pending_q) begin
            req_addr_d = redirect_pc_q;
            pending_d  = 1'b0;
          end else begin
            instr_d    = imem.imem_rdata;
            pc_d       = req_addr_q;
            req_addr_d = req_addr_q + ADDR_STEP;
          end
        end else if (branch_taken) begin
          pending_d     = 1'b1;
          redirect_pc_d = target_aligned;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          req_addr_d = target_aligned;
        end
      end
      default: begin
        req_addr_d = req_addr_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pending_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      req_addr_q    <= req_addr_d;
      redirect_pc_q <= redirect_pc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pending_q     <= pending_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = req_addr_q;
  assign instruction    = instr_q;
  assign Opcode         = instr_q[OPC_W-1:0];
  assign pc             = pc_q;
  assign instr_valid    = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a capture scoreboard.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [31:0] pc;
  logic        instr_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic prev_valid = 1'b0;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (ifc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruction   (instruction),
    .Opcode        (opcode),
    .pc            (pc),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  // Memory contents are a function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // One clock: drive inputs, optionally record an expected capture, then score new valids
  task automatic step(input logic ack, input logic bt, input logic [31:0] tgt,
                      input logic st, input logic push);
    exp_t e;
    exp_t got;
    ifc.imem_ack   = ack;
    ifc.imem_rdata = ack ? mem_word(ifc.imem_addr) : 32'hBADB_AD00;
    branch_taken   = bt;
    branch_target  = tgt;
    stall          = st;
    if (push) begin
      e.pc    = ifc.imem_addr;
      e.instr = mem_word(ifc.imem_addr);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (instr_valid && !prev_valid) begin
      chk("sb_expected", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        got = sb_q.pop_front();
        chk("sb_pc", pc, got.pc);
        chk("sb_instr", instruction, got.instr);
        chk("sb_opcode", 32'(opcode), 32'(got.instr[6:0]));
      end
    end
    prev_valid = instr_valid;
  endtask

  task automatic check_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(ifc.imem_req), 32'd1);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_addr"}, ifc.imem_addr, addr);
  endtask

  task automatic check_hold(input string tag, input logic [31:0] exp_pc);
    chk({tag, "_req"}, 32'(ifc.imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_instr"}, instruction, mem_word(exp_pc));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(ifc.imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_addr"}, ifc.imem_addr, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instruction, NOP);
    chk({tag, "_opcode"}, 32'(opcode), 32'h13);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    stall          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = 32'h0;
    ifc.imem_ack   = 1'b0;
    ifc.imem_rdata = 32'h0;

    // Reset wins over branch/ack in the same cycle
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
    check_reset("reset");
    reset = 1'b0;

    // IDLE ignores ack, then zero-wait fetches at 0, 4, 8
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("idle_exit", 32'h0);
    chk("idle_no_capture", instruction, NOP);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("zw0", 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("zw1", 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("zw1", 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("zw2", 32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("zw2", 32'h8);

    // Stall holds the instruction for five cycles
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check_hold("stall", 32'h8);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("stall_drop", 32'hC);

    // Ack delayed three cycles at 0x10
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("wait_start", 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      check_req("wait", 32'h10);
      chk("wait_instr", instruction, mem_word(32'hC));
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("late_ack", 32'h10);

    // Branch from HOLD despite stall
    step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0);
    check_req("hold_branch", 32'h20);

    // Branch during outstanding read: data discarded, aligned target fetched
    step(1'b0, 1'b1, 32'h103, 1'b0, 1'b0);
    check_req("pend_set", 32'h20);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("pend_wait", 32'h20);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("discard", 32'h100);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("redirect", 32'h100);

    // Second branch while pending overwrites the redirect
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("ow_start", 32'h104);
    step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    check_req("ow_first", 32'h104);
    step(1'b0, 1'b1, 32'h402, 1'b0, 1'b0);
    check_req("ow_second", 32'h104);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("overwrite", 32'h400);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("ow_fetch", 32'h400);

    // Branch coincident with ack; then live branch beats pending redirect
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("co_start", 32'h404);
    step(1'b1, 1'b1, 32'h50, 1'b0, 1'b0);
    check_req("coincide", 32'h50);
    step(1'b0, 1'b1, 32'h60, 1'b0, 1'b0);
    check_req("prio_pend", 32'h50);
    step(1'b1, 1'b1, 32'h70, 1'b0, 1'b0);
    check_req("bt_priority", 32'h70);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("prio_fetch", 32'h70);

    // Address wrap at the top of the space
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_req("top", 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("top", 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("wrap", 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("wrap", 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("pre_rst", 32'h4);

    // Reset mid-REQ beats ack/branch/stall; later ack in IDLE is ignored
    reset = 1'b1;
    step(1'b1, 1'b1, 32'h80, 1'b1, 1'b0);
    check_reset("mid_rst");
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("post_rst", 32'h0);
    chk("post_rst_instr", instruction, NOP);

    // Branch in IDLE redirects the first fetch
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h207, 1'b0, 1'b0);
    check_req("idle_branch", 32'h204);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("idle_branch", 32'h204);

    // Reset clears a pending redirect
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("rp_start", 32'h208);
    step(1'b0, 1'b1, 32'h900, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_reset("rp_rst");
    reset = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check_req("rp_req", 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_hold("rp_fetch", 32'h0);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
